// File: rtl/inst_fetch_buffer_if.sv
// Bundle of the fetch-stage signals: PC side, pipeline control, instruction
// memory port and the decode-facing FIFO head.
interface inst_fetch_buffer_if;
  logic [5:0]  stall;
  logic        br;
  logic [31:0] pc_i;
  logic        right_one_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_rdata_i;
  logic        if_valid_o;
  logic [31:0] if_pc_o;
  logic [31:0] if_inst_o;
  logic        stallreq_o;

  modport slave (
    input  stall, br, pc_i, right_one_i, imem_ack_i, imem_rdata_i,
    output imem_req_o, imem_addr_o, if_valid_o, if_pc_o, if_inst_o, stallreq_o
  );

  modport master (
    output stall, br, pc_i, right_one_i, imem_ack_i, imem_rdata_i,
    input  imem_req_o, imem_addr_o, if_valid_o, if_pc_o, if_inst_o, stallreq_o
  );
endinterface

// File: rtl/inst_fetch_buffer.sv
// Instruction fetch stage: issues one outstanding instruction-memory read at
// a time and queues returned {pc, instruction} pairs for decode. Every request
// reserves a FIFO slot when it is issued, so a returning read always fits.
// A branch empties the queue and turns an in-flight read into a discarded one.
module inst_fetch_buffer #(
  parameter int          DEPTH = 2,
  parameter logic [31:0] NOP   = 32'h00000013
) (
  input  logic                  clk,
  input  logic                  rst,
  inst_fetch_buffer_if.slave    bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic            req, req_nxt;
  logic [31:0]     addr, addr_nxt;
  logic [CW-1:0]   count;
  logic [CW-1:0]   occ;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [31:0]     pc_mem   [DEPTH];
  logic [31:0]     inst_mem [DEPTH];
  logic            valid, pop, ack, push, room, accept;
  logic            stall_unused;

  // Upper stall bits belong to later pipeline stages.
  assign stall_unused = ^bus.stall[5:2];

  assign valid  = (count != {CW{1'b0}});
  assign ack    = bus.imem_ack_i & req;
  assign pop    = valid & ~bus.stall[1];
  assign occ    = count - {{(CW-1){1'b0}}, pop};
  assign push   = (state == REQ) & ack & ~bus.br;
  assign accept = ~rst & bus.right_one_i & ~bus.stall[0] & ~bus.br & room;

  assign bus.stallreq_o  = bus.right_one_i & ~accept;
  assign bus.imem_req_o  = req;
  assign bus.imem_addr_o = addr;
  assign bus.if_valid_o  = valid;
  assign bus.if_pc_o     = valid ? pc_mem[rd_ptr]   : 32'h00000000;
  assign bus.if_inst_o   = valid ? inst_mem[rd_ptr] : NOP;

  // Space check: a new read needs a free slot beyond any read still owed a slot.
  always_comb begin
    room = 1'b0;
    case (state)
      IDLE:    room = (occ < CW'(DEPTH));
      REQ:     room = ack & ((occ + CW'(1)) < CW'(DEPTH));
      DROP:    room = 1'b0;
      default: room = 1'b0;
    endcase
  end

  // Next-state and memory-port register values.
  always_comb begin
    state_nxt = state;
    req_nxt   = req;
    addr_nxt  = addr;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = REQ;
          req_nxt   = 1'b1;
          addr_nxt  = bus.pc_i;
        end else begin
          state_nxt = IDLE;
        end
      end
      REQ: begin
        if (bus.br) begin
          if (ack) begin
            state_nxt = IDLE;
            req_nxt   = 1'b0;
          end else begin
            state_nxt = DROP;
          end
        end else if (ack) begin
          if (accept) begin
            state_nxt = REQ;
            addr_nxt  = bus.pc_i;
          end else begin
            state_nxt = IDLE;
            req_nxt   = 1'b0;
          end
        end else begin
          state_nxt = REQ;
        end
      end
      DROP: begin
        if (ack) begin
          state_nxt = IDLE;
          req_nxt   = 1'b0;
        end else begin
          state_nxt = DROP;
        end
      end
      default: begin
        state_nxt = IDLE;
        req_nxt   = 1'b0;
      end
    endcase
  end

  // Control state and memory request registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      req   <= 1'b0;
      addr  <= 32'h00000000;
    end else begin
      state <= state_nxt;
      req   <= req_nxt;
      addr  <= addr_nxt;
    end
  end

  // FIFO occupancy and pointers; a branch empties the queue.
  always_ff @(posedge clk) begin
    if (rst || bus.br) begin
      count  <= {CW{1'b0}};
      wr_ptr <= {PW{1'b0}};
      rd_ptr <= {PW{1'b0}};
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage: returned instruction tagged with the address it was read from.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]   <= addr;
      inst_mem[wr_ptr] <= bus.imem_rdata_i;
    end
  end

endmodule

// File: tb/tb_inst_fetch_buffer.sv
// Bench for inst_fetch_buffer: directed phases followed by random traffic,
// checked each cycle against a transaction-level model built on a queue.
module tb_inst_fetch_buffer;

  localparam int          DEPTH = 2;
  localparam logic [31:0] NOP   = 32'h00000013;
  localparam logic [31:0] KEY   = 32'hA5A50000;

  logic clk;
  logic rst;
  inst_fetch_buffer_if bus ();

  inst_fetch_buffer #(.DEPTH(DEPTH), .NOP(NOP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Model: queued {pc, inst}; one read may be outstanding, possibly to be discarded.
  logic [63:0] q[$];
  bit          m_out  = 1'b0;
  bit          m_disc = 1'b0;
  logic [31:0] m_addr = 32'h0;
  int          age    = 0;
  logic [31:0] pc_cur = 32'h0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic cycle(input logic r, input logic [5:0] st, input logic b,
                       input logic ro, input logic ak, input bit chk);
    bit   ackv, pop, push, acc;
    int   after;
    logic [31:0] e_pc, e_inst;
    rst              = r;
    bus.stall        = st;
    bus.br           = b;
    bus.pc_i         = pc_cur;
    bus.right_one_i  = ro;
    bus.imem_ack_i   = ak;
    bus.imem_rdata_i = m_addr ^ KEY;
    #1;
    ackv  = ak && m_out;
    push  = ackv && !m_disc && !b;
    pop   = (q.size() > 0) && !st[1];
    // Entries held after this cycle plus the slot the new read will need.
    after = q.size() - (pop ? 1 : 0) + (push ? 1 : 0) + 1;
    acc   = !r && ro && !st[0] && !b && !m_disc && (!m_out || ackv) && (after <= DEPTH);
    e_pc   = (q.size() > 0) ? q[0][63:32] : 32'h0;
    e_inst = (q.size() > 0) ? q[0][31:0]  : NOP;
    if (chk) begin
      check("imem_req",  {31'h0, bus.imem_req_o}, {31'h0, m_out});
      check("imem_addr", bus.imem_addr_o, m_addr);
      check("if_valid",  {31'h0, bus.if_valid_o}, {31'h0, (q.size() > 0)});
      check("if_pc",     bus.if_pc_o, e_pc);
      check("if_inst",   bus.if_inst_o, e_inst);
      check("stallreq",  {31'h0, bus.stallreq_o}, {31'h0, (ro && !acc)});
    end
    if (r) begin
      q.delete();
      m_out = 1'b0; m_disc = 1'b0; m_addr = 32'h0; age = 0;
    end else begin
      if (b) q.delete();
      else begin
        if (pop)  void'(q.pop_front());
        if (push) q.push_back({m_addr, m_addr ^ KEY});
      end
      if (ackv) begin m_out = 1'b0; m_disc = 1'b0; end
      if (b && m_out) m_disc = 1'b1;
      if (acc) begin
        m_out = 1'b1; m_disc = 1'b0; m_addr = pc_cur; age = 0;
        pc_cur = pc_cur + 32'd4;
      end else if (m_out) age++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // wt < 0: random acks (also when nothing is outstanding); otherwise ack after wt wait cycles.
  task automatic run(input int n, input int wt, input int s0_pct, input int s1_pct,
                     input int br_pct, input int ro_pct);
    logic [5:0] st;
    logic       b, ro, ak;
    for (int i = 0; i < n; i++) begin
      ak = (wt < 0) ? ($urandom_range(0, 1) == 1) : (m_out && age >= wt);
      b  = (int'($urandom_range(0, 99)) < br_pct);
      if (b) pc_cur = $urandom & 32'h0000FFFC;
      st[5:2] = 4'($urandom);
      st[0]   = (int'($urandom_range(0, 99)) < s0_pct);
      st[1]   = (int'($urandom_range(0, 99)) < s1_pct);
      ro      = (int'($urandom_range(0, 99)) < ro_pct);
      cycle(1'b0, st, b, ro, ak, 1'b1);
    end
  endtask

  initial begin
    // Reset for two cycles with a valid PC presented.
    pc_cur = 32'h0;
    cycle(1'b1, 6'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 6'h00, 1'b0, 1'b1, 1'b0, 1'b1);
    // Streaming with zero-wait memory.
    run(12, 0, 0, 0, 0, 100);
    // Memory wait states of three cycles.
    run(16, 3, 0, 0, 0, 100);
    // Full buffer: decode holds, then releases.
    run(8, 0, 0, 100, 0, 100);
    run(5, 0, 0, 0, 0, 100);
    // Branch while a slow read is in flight.
    run(2, 3, 0, 0, 0, 100);
    pc_cur = 32'h00000100;
    cycle(1'b0, 6'h00, 1'b1, 1'b1, 1'b0, 1'b1);
    run(12, 3, 0, 0, 0, 100);
    // Ack, pop and branch in the same cycle.
    run(4, 0, 0, 0, 0, 100);
    pc_cur = 32'h00000200;
    cycle(1'b0, 6'h00, 1'b1, 1'b1, 1'b1, 1'b1);
    run(6, 0, 0, 0, 0, 100);
    // Ack with pop while full under back-to-back traffic.
    run(3, 0, 0, 100, 0, 100);
    cycle(1'b0, 6'h00, 1'b0, 1'b1, 1'b1, 1'b1);
    run(4, 0, 0, 0, 0, 100);
    // Reset mid-read, then a late ack that must be ignored.
    run(2, 3, 0, 0, 0, 100);
    cycle(1'b1, 6'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 6'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    run(4, 0, 0, 0, 0, 100);
    // Random traffic.
    run(600, -1, 20, 30, 5, 80);
    run(200, 2, 10, 40, 3, 90);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/inst_fetch_buffer.md
# inst_fetch_buffer

Instruction-fetch stage that consumes the program counter's `pc_o`/`right_one_o` outputs, issues one-at-a-time instruction-memory reads with a req/ack handshake, and buffers returned instructions with their PCs in a small FIFO for the decode stage. It raises `stallreq_o` to hold the PC whenever the current address cannot be accepted. On a branch (`br`) it flushes the FIFO and discards any in-flight read.

## Interface
- `DEPTH`, 2: FIFO entries; power of two, at least 2.
- `NOP`, 32'h00000013: instruction driven on `if_inst_o` when the FIFO is empty.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `stall`  in  6  pipeline stall vector; `stall[0]` = PC hold, `stall[1]` = IF/decode hold.
- `br`  in  1  branch taken; flush request.
- `pc_i`  in  32  current PC, from the PC's `pc_o`.
- `right_one_i`  in  1  PC valid, from the PC's `right_one_o`.
- `imem_req_o`  out  1  memory read request; registered.
- `imem_addr_o`  out  32  read address; registered, stable while `imem_req_o` is high.
- `imem_ack_i`  in  1  read complete; `imem_rdata_i` is valid in the same cycle.
- `imem_rdata_i`  in  32  read data.
- `if_valid_o`  out  1  FIFO head valid.
- `if_pc_o`  out  32  PC of the FIFO head.
- `if_inst_o`  out  32  instruction at the FIFO head, or `NOP` when empty.
- `stallreq_o`  out  1  combinational; asks the controller to hold the PC.

## Operation
- **States:**
  - IDLE: no read outstanding.
  - REQ: read outstanding, response will be kept.
  - DROP: read outstanding, response will be discarded.
- **Derived signals:**
  - `pop` = `if_valid_o & ~stall[1]`.
  - `ack` = `imem_ack_i & imem_req_o`.
- **Accept condition:** `right_one_i & ~stall[0] & ~br`, plus:
  - IDLE: `count - pop < DEPTH`.
  - REQ: `ack` and `count - pop + 1 < DEPTH`.
  - DROP: never.
- **On accept:**
  - `imem_addr_o <= pc_i`.
  - `imem_req_o <= 1`.
  - Next state REQ.
- **Transitions:**
  - REQ with `ack` and no accept: next state IDLE, `imem_req_o <= 0`.
  - REQ with `ack` and accept: stay in REQ with the new address. Back-to-back requests are allowed.
- **Push:** in REQ, `ack & ~br` writes `{imem_addr_o, imem_rdata_i}` to the FIFO tail.
- **Pop:** on `pop`, the head advances.
- **Push and pop in the same cycle:** `count` is unchanged.
- **`stallreq_o`** = `right_one_i & ~accept`. It is 0 when `right_one_i` = 0.
- **Branch (`br` = 1):**
  - FIFO cleared: `count <= 0`, pointers reset.
  - Nothing is pushed or accepted that cycle.
  - REQ without `ack`: next state DROP, `imem_req_o` stays 1.
  - REQ with `ack`: response dropped, next state IDLE.
  - IDLE: stays IDLE.
- **DROP:** `imem_req_o` stays high until `ack`. The data is discarded and the next state is IDLE. `br` arriving again while in DROP keeps the state in DROP.
- **Count:** `count` ranges 0..DEPTH. Pointers are `log2(DEPTH)` bits wide and wrap modulo DEPTH.

## Timing
- **Reset values:**
  - state IDLE, `count` = 0.
  - `imem_req_o` = 0, `imem_addr_o` = 0.
  - `if_valid_o` = 0, `if_pc_o` = 0, `if_inst_o` = `NOP`.
  - `stallreq_o` follows its equation, so it equals `right_one_i` while in reset.
- **Reset mid-read:** abandons the read. A late `imem_ack_i` after reset is ignored because `imem_req_o` = 0.
- **Fetch latency:**
  - Accept in cycle t.
  - `imem_req_o` high from t+1.
  - `ack` earliest in t+1.
  - Entry visible on `if_valid_o` and `if_inst_o` in t+2.
- **Memory contract:** `imem_addr_o` must not change while `imem_req_o` = 1 and `ack` = 0.
- **Output source:** `if_*` outputs come from FIFO storage and pointers; there is no combinational path from `imem_rdata_i`.
- **Sustained throughput:** with zero-wait memory (ack in the first request cycle), `DEPTH` ≥ 2 and no downstream stall, one instruction per cycle.

## Test plan
- **Reset:** `rst` = 1 for 2 cycles, `right_one_i` = 1. Required: `imem_req_o` = 0, `if_valid_o` = 0, `if_inst_o` = 0x00000013, `stallreq_o` = 1. After release, `imem_req_o` = 1 next cycle with `imem_addr_o` = `pc_i`.
- **Streaming:** zero-wait memory returns `addr ^ 32'hA5A50000`, PC steps 0x0, 0x4, 0x8…, `stall` = 0. Required: from t+2, one entry per cycle in order, e.g. `if_pc_o` = 0x4 with `if_inst_o` = 0xA5A50004, and `stallreq_o` = 0 throughout.
- **Memory wait states:** `ack` delayed 3 cycles. Required: `imem_addr_o` held constant, `stallreq_o` = 1 for those cycles, no duplicate or lost entries.
- **Full buffer:** `stall[1]` = 1 with `DEPTH` = 2. Required: after 2 pushes, no new request and `stallreq_o` = 1. Releasing `stall[1]` gives a pop, and an accept in the same cycle.
- **Branch with read in flight:** `br` pulsed while in REQ before `ack`. Required: `if_valid_o` = 0 next cycle; the late ack data is not pushed; the next accept uses the new `pc_i` (e.g. 0x100) and its entry is delivered.
- **Simultaneous events:** ack, pop and `br` in the same cycle. Required: FIFO empty, state IDLE, nothing pushed. Also ack with pop while full: `count` unchanged and back-to-back accept allowed.
